inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 32 +++
 rtl/inst_fetch_queue.sv | 90 +++++++++
 rtl/inst_fetch.sv | 217 +++++++++++++++++++++
 tb/tb_inst_fetch.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared definitions for the instruction fetch unit.
//               - 2-bit fetch FSM state encodings
//               - default reset PC
//               - instruction queue entry width ({pc, inst, adel})
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    // Default address width and the matching queue entry width.
    localparam int unsigned c_ADDR_WIDTH  = 32;
    localparam int unsigned c_ENTRY_WIDTH = c_ADDR_WIDTH + 33;

    // First fetch address after reset (MIPS boot vector).
    localparam logic [31:0] c_RESET_PC = 32'hBFC0_0000;

    // Fetch FSM state encodings.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t c_ST_RUN       = 2'd0;
    localparam fetch_state_t c_ST_MISS      = 2'd1;
    localparam fetch_state_t c_ST_MISS_KILL = 2'd2;
    localparam fetch_state_t c_ST_HALT      = 2'd3;

    // Queue entry width for a given address width: pc + 32-bit inst + adel.
    function automatic int unsigned entry_width(input int unsigned addr_width);
        return addr_width + 33;
    endfunction

endpackage : inst_fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Parameterised synchronous FIFO holding fetched instructions.
//               The head entry is presented from a register, so pop_data has
//               no combinational path from push_data.
// Ports       : clk        - clock
//               rst        - asynchronous active-low reset
//               clear      - flush all entries (priority over push/pop)
//               push       - append push_data at the tail
//               push_data  - entry to append
//               pop        - remove the head entry
//               pop_data   - current head entry
//               full/empty - occupancy flags
//               count      - number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = c_ENTRY_WIDTH,
    parameter int unsigned DEPTH = 4
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop && !w_empty;
    // A push into a full queue is accepted only when the head leaves at the
    // same edge; DEPTH is a power of two so the pointers wrap naturally.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= r_tail + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_head];
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch unit. Walks the PC through the instruction
//               cache, buffers fetched words in a small FIFO toward decode,
//               handles cache misses, branch/exception redirects and
//               misaligned fetch addresses (address-error entries).
// Ports       : clk         - clock
//               rst         - asynchronous active-low reset
//               redirect    - one-cycle redirect request
//               redirect_pc - redirect target
//               read_en     - cache read request
//               addr_read   - cache address (the PC register)
//               ready       - cache data valid for addr_read this cycle
//               data_out    - cache instruction word
//               out_valid   - queue head valid toward decode
//               out_ready   - decode accepts the head
//               out_pc      - head PC
//               out_inst    - head instruction
//               out_adel    - head carries an instruction address error
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(c_RESET_PC)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] addr_read,
    input  logic                  ready,
    input  logic [31:0]           data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [31:0]           out_inst,
    output logic                  out_adel
);

    localparam int unsigned c_EW    = entry_width(ADDR_WIDTH);
    localparam int unsigned c_CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH-1:0] r_pend_pc;
    logic [ADDR_WIDTH-1:0] w_pend_next;

    logic                  w_fetch;
    logic                  w_push;
    logic                  w_push_adel;
    logic                  w_clear;
    logic                  w_pop;
    logic                  w_has_space;
    logic                  w_misaligned;

    logic                  w_q_full;
    logic                  w_q_empty;
    logic [c_CNT_W-1:0]    w_q_count;
    logic [c_EW-1:0]       w_push_data;
    logic [c_EW-1:0]       w_head;

    // Space is judged from the registered count only, so a pop in the same
    // cycle never opens a fetch slot (keeps ready/out_ready paths apart).
    assign w_has_space  = (w_q_count < c_CNT_W'(QUEUE_DEPTH));
    assign w_misaligned = (r_pc[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // State / PC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_RUN;
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_pend_pc <= w_pend_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            c_ST_RUN: begin
                if (redirect) begin
                    w_state_next = c_ST_RUN;
                end else if (w_misaligned) begin
                    // Address-error entry needs a free slot before halting.
                    if (!w_q_full) begin
                        w_state_next = c_ST_HALT;
                    end
                end else if (w_has_space && !ready) begin
                    w_state_next = c_ST_MISS;
                end
            end
            c_ST_MISS: begin
                // A redirect always wins: the refill in flight must still
                // complete on the old address, so wait it out in MISS_KILL.
                if (redirect) begin
                    w_state_next = c_ST_MISS_KILL;
                end else if (ready) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_MISS_KILL: begin
                if (ready) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_HALT: begin
                if (redirect) begin
                    w_state_next = c_ST_RUN;
                end
            end
            default: w_state_next = c_ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch     = 1'b0;
        w_push      = 1'b0;
        w_push_adel = 1'b0;
        w_clear     = 1'b0;
        w_pc_next   = r_pc;
        w_pend_next = r_pend_pc;
        unique case (r_state)
            c_ST_RUN: begin
                w_fetch = w_has_space && !w_misaligned;
                if (redirect) begin
                    w_clear   = 1'b1;
                    w_pc_next = redirect_pc;
                end else if (w_misaligned) begin
                    if (!w_q_full) begin
                        w_push      = 1'b1;
                        w_push_adel = 1'b1;
                    end
                end else if (w_fetch && ready) begin
                    w_push    = 1'b1;
                    w_pc_next = r_pc + ADDR_WIDTH'(4);
                end
            end
            c_ST_MISS: begin
                // addr_read (r_pc) stays put until the refill completes.
                w_fetch = 1'b1;
                if (redirect) begin
                    w_pend_next = redirect_pc;
                end else if (ready) begin
                    w_push    = 1'b1;
                    w_pc_next = r_pc + ADDR_WIDTH'(4);
                end
            end
            c_ST_MISS_KILL: begin
                w_fetch = 1'b1;
                if (ready) begin
                    // Refill data belongs to the abandoned path: drop it and
                    // flush. A redirect landing on this cycle is the newest.
                    w_clear   = 1'b1;
                    w_pc_next = redirect ? redirect_pc : r_pend_pc;
                end else if (redirect) begin
                    w_pend_next = redirect_pc;
                end
            end
            c_ST_HALT: begin
                if (redirect) begin
                    w_clear   = 1'b1;
                    w_pc_next = redirect_pc;
                end
            end
            default: begin
                w_fetch = 1'b0;
            end
        endcase
    end

    assign w_push_data = {r_pc, (w_push_adel ? 32'h0 : data_out), w_push_adel};
    assign w_pop       = !w_q_empty && out_ready;

    fetch_queue #(
        .WIDTH (c_EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_q_full),
        .empty     (w_q_empty),
        .count     (w_q_count)
    );

    // No cache request may be seen while the unit is held in reset.
    assign read_en   = rst && w_fetch;
    assign addr_read = r_pc;
    assign out_valid = !w_q_empty;
    assign out_pc    = w_head[c_EW-1 -: ADDR_WIDTH];
    assign out_inst  = w_head[32:1];
    assign out_adel  = w_head[0];

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking testbench for inst_fetch: directed scenarios
//               plus a randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [31:0] c_RST_PC = 32'hBFC0_0000;
    localparam int          c_DEPTH  = 4;

    // Reference model activity modes.
    localparam int M_FETCHING = 0;
    localparam int M_WAITING  = 1;
    localparam int M_DISCARD  = 2;
    localparam int M_STOPPED  = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        read_en;
    logic [31:0] addr_read;
    logic        ready;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    int n_checks;
    int n_fail;

    // Reference model state
    ent_t        mq[$];
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_pend;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        ent_t e;
        e.pc   = pc;
        e.inst = inst;
        e.adel = adel;
        return e;
    endfunction

    // Cache model: always returns the word belonging to the requested address.
    assign data_out = inst_of(addr_read);

    inst_fetch #(
        .ADDR_WIDTH  (32),
        .QUEUE_DEPTH (c_DEPTH),
        .RESET_PC    (c_RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .read_en     (read_en),
        .addr_read   (addr_read),
        .ready       (ready),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_adel    (out_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse reset for one cycle; returns at a negedge just after release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; redirect = 1'b0; ready = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++;
        if ({read_en, addr_read, out_valid, out_pc, out_inst, out_adel} !==
            {1'b0, c_RST_PC, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: read_en=%b addr=%h valid=%b pc=%h inst=%h adel=%b, required 0 %h 0 0 0 0",
                     read_en, addr_read, out_valid, out_pc, out_inst, out_adel, c_RST_PC);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (read_en !== 1'b1 || addr_read !== c_RST_PC) begin
            n_fail++;
            $display("FAIL reset_release: read_en=%b addr=%h, required 1 %h", read_en, addr_read, c_RST_PC);
        end
    endtask

    task automatic test_hit_stream();
        logic [31:0] exp;
        do_reset();
        ready = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            exp = c_RST_PC + 32'(4 * i);
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== exp || out_inst !== inst_of(exp) || out_adel !== 1'b0) begin
                n_fail++;
                $display("FAIL hit_stream[%0d]: valid=%b pc=%h inst=%h, required 1 %h %h",
                         i, out_valid, out_pc, out_inst, exp, inst_of(exp));
            end
        end
    endtask

    task automatic test_miss();
        do_reset();
        ready = 1'b0; out_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hBFC0_0010;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (read_en !== 1'b1 || addr_read !== 32'hBFC0_0010) begin
                n_fail++;
                $display("FAIL miss_hold[%0d]: read_en=%b addr=%h, required 1 bfc00010", i, read_en, addr_read);
            end
            @(negedge clk);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #1;
        n_checks++;
        if (addr_read !== 32'hBFC0_0014 || out_valid !== 1'b1 || out_pc !== 32'hBFC0_0010 ||
            out_inst !== inst_of(32'hBFC0_0010)) begin
            n_fail++;
            $display("FAIL miss_refill: addr=%h valid=%b pc=%h inst=%h, required bfc00014 1 bfc00010 %h",
                     addr_read, out_valid, out_pc, out_inst, inst_of(32'hBFC0_0010));
        end
    endtask

    task automatic test_redirect_in_miss();
        do_reset();
        ready = 1'b1; out_ready = 1'b0;
        @(negedge clk);               // push BFC00000
        @(negedge clk);               // push BFC00004
        ready = 1'b0;
        @(negedge clk);               // miss cycle 1 at BFC00008
        @(negedge clk);               // miss cycle 2
        @(negedge clk);               // miss cycle 3
        redirect = 1'b1; redirect_pc = 32'h8000_0180;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++;
        if (read_en !== 1'b1 || addr_read !== 32'hBFC0_0008 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_hold: read_en=%b addr=%h valid=%b, required 1 bfc00008 1", read_en, addr_read, out_valid);
        end
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #1;
        n_checks++;
        if (addr_read !== 32'h8000_0180 || out_valid !== 1'b0 || read_en !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_resume: addr=%h valid=%b read_en=%b, required 80000180 0 1", addr_read, out_valid, read_en);
        end
    endtask

    task automatic test_full_queue();
        int pushes;
        do_reset();
        ready = 1'b1; out_ready = 1'b0; pushes = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (read_en === 1'b1) pushes++;
            @(negedge clk);
        end
        n_checks++;
        if (pushes !== 4) begin
            n_fail++;
            $display("FAIL full_push_count: pushes=%0d, required 4", pushes);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (read_en !== 1'b0 || out_pc !== c_RST_PC) begin
            n_fail++;
            $display("FAIL full_stall: read_en=%b head=%h, required 0 %h", read_en, out_pc, c_RST_PC);
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (read_en !== 1'b1 || addr_read !== 32'hBFC0_0010 || out_pc !== 32'hBFC0_0004) begin
            n_fail++;
            $display("FAIL full_after_pop: read_en=%b addr=%h head=%h, required 1 bfc00010 bfc00004",
                     read_en, addr_read, out_pc);
        end
        @(negedge clk); #1;
        n_checks++;
        if (read_en !== 1'b0 || addr_read !== 32'hBFC0_0014) begin
            n_fail++;
            $display("FAIL full_refill: read_en=%b addr=%h, required 0 bfc00014", read_en, addr_read);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        ready = 1'b1; out_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h8000_0002;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++;
        if (read_en !== 1'b0 || addr_read !== 32'h8000_0002) begin
            n_fail++;
            $display("FAIL adel_no_fetch: read_en=%b addr=%h, required 0 80000002", read_en, addr_read);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (read_en !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h8000_0002 ||
                out_inst !== 32'h0 || out_adel !== 1'b1) begin
                n_fail++;
                $display("FAIL adel_entry[%0d]: read_en=%b valid=%b pc=%h inst=%h adel=%b, required 0 1 80000002 0 1",
                         i, read_en, out_valid, out_pc, out_inst, out_adel);
            end
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (read_en !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL adel_halted: read_en=%b valid=%b, required 0 0", read_en, out_valid);
        end
        redirect = 1'b1; redirect_pc = 32'h8000_0000;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++;
        if (read_en !== 1'b1 || addr_read !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL adel_resume: read_en=%b addr=%h, required 1 80000000", read_en, addr_read);
        end
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_adel !== 1'b0 ||
            out_inst !== inst_of(32'h8000_0000)) begin
            n_fail++;
            $display("FAIL adel_resume_entry: valid=%b pc=%h adel=%b inst=%h, required 1 80000000 0 %h",
                     out_valid, out_pc, out_adel, out_inst, inst_of(32'h8000_0000));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        ready = 1'b0;                 // 3 entries queued; next edge enters a miss
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || read_en !== 1'b1 || addr_read !== 32'hBFC0_000C) begin
            n_fail++;
            $display("FAIL mid_pre: valid=%b read_en=%b addr=%h, required 1 1 bfc0000c", out_valid, read_en, addr_read);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || addr_read !== c_RST_PC || read_en !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: valid=%b addr=%h read_en=%b, required 0 %h 0", out_valid, addr_read, read_en, c_RST_PC);
        end
        @(negedge clk);
        rst = 1'b1;
        ready = 1'b1;
        #1;
        n_checks++;
        if (read_en !== 1'b1 || addr_read !== c_RST_PC || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: read_en=%b addr=%h valid=%b, required 1 %h 0", read_en, addr_read, out_valid, c_RST_PC);
        end
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== c_RST_PC || addr_read !== c_RST_PC + 32'd4) begin
            n_fail++;
            $display("FAIL mid_restart: valid=%b pc=%h addr=%h, required 1 %h %h",
                     out_valid, out_pc, addr_read, c_RST_PC, c_RST_PC + 32'd4);
        end
    endtask

    // Advance the reference model across one clock edge.
    task automatic model_step(input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
        bit popd;
        bit space;
        popd  = (mq.size() > 0) && ordy;
        space = (mq.size() < c_DEPTH);
        case (m_mode)
            M_FETCHING: begin
                if (redir) begin
                    mq.delete();
                    m_pc = rpc;
                end else begin
                    if (popd) void'(mq.pop_front());
                    if (m_pc[1:0] != 2'b00) begin
                        if (space) begin
                            mq.push_back(mk(m_pc, 32'h0, 1'b1));
                            m_mode = M_STOPPED;
                        end
                    end else if (space) begin
                        if (rdy) begin
                            mq.push_back(mk(m_pc, inst_of(m_pc), 1'b0));
                            m_pc = m_pc + 32'd4;
                        end else begin
                            m_mode = M_WAITING;
                        end
                    end
                end
            end
            M_WAITING: begin
                if (popd) void'(mq.pop_front());
                if (redir) begin
                    m_pend = rpc;
                    m_mode = M_DISCARD;
                end else if (rdy) begin
                    mq.push_back(mk(m_pc, inst_of(m_pc), 1'b0));
                    m_pc   = m_pc + 32'd4;
                    m_mode = M_FETCHING;
                end
            end
            M_DISCARD: begin
                if (rdy) begin
                    mq.delete();
                    m_pc   = redir ? rpc : m_pend;
                    m_mode = M_FETCHING;
                end else begin
                    if (popd) void'(mq.pop_front());
                    if (redir) m_pend = rpc;
                end
            end
            default: begin
                if (redir) begin
                    mq.delete();
                    m_pc   = rpc;
                    m_mode = M_FETCHING;
                end else if (popd) begin
                    void'(mq.pop_front());
                end
            end
        endcase
    endtask

    task automatic test_random();
        bit          exp_re;
        logic [31:0] rpc;
        int          sel;
        do_reset();
        mq.delete();
        m_mode = M_FETCHING;
        m_pc   = c_RST_PC;
        m_pend = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            #1;
            exp_re = ((m_mode == M_FETCHING) && (mq.size() < c_DEPTH) && (m_pc[1:0] == 2'b00)) ||
                     (m_mode == M_WAITING) || (m_mode == M_DISCARD);
            n_checks++;
            if (read_en !== exp_re || addr_read !== m_pc || out_valid !== (mq.size() > 0)) begin
                n_fail++;
                $display("FAIL rand_ctrl@%0d: read_en=%b addr=%h valid=%b, required %b %h %b",
                         cyc, read_en, addr_read, out_valid, exp_re, m_pc, (mq.size() > 0));
            end
            if (mq.size() > 0) begin
                n_checks++;
                if (out_pc !== mq[0].pc || out_inst !== mq[0].inst || out_adel !== mq[0].adel) begin
                    n_fail++;
                    $display("FAIL rand_head@%0d: pc=%h inst=%h adel=%b, required %h %h %b",
                             cyc, out_pc, out_inst, out_adel, mq[0].pc, mq[0].inst, mq[0].adel);
                end
            end
            ready     = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            redirect  = ($urandom_range(0, 11) == 0);
            sel       = int'($urandom_range(0, 7));
            if (sel == 0) begin
                rpc = 32'hFFFF_FFFC;
            end else if (sel == 1) begin
                rpc = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            end else begin
                rpc = $urandom() & 32'hFFFF_FFFC;
            end
            redirect_pc = rpc;
            model_step(ready, out_ready, redirect, rpc);
            @(negedge clk);
        end
        redirect = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        ready       = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_hit_stream();
        test_miss();
        test_redirect_in_miss();
        test_full_queue();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch
`default_nettype wire
